// File: rtl/div_freq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_freq_ctrl                                              |
// | Description : Run-time controller for a programmable frequency divider.  |
// |               Start/stop sequencing, valid/ready divisor loading with    |
// |               glitch-free changeover at period boundaries, a 1-cycle     |
// |               tick strobe and a square low_clock in the speed_clock      |
// |               domain.                                                    |
// | Optional    : define DIV_TICK_COUNT_EN to add the tick_count output      |
// |               (ticks since the last IDLE->RUN entry, 16-bit wrapping).   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// Ports:
//   speed_clock  in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   level, leaves IDLE when stop is low
//   stop         in   level, returns to IDLE (wins over start)
//   cfg_valid    in   new divisor offered
//   cfg_div      in   divisor, legal range 2..2^CNT_W-1
//   cfg_ready    out  divisor can be accepted this cycle
//   cfg_err      out  1-cycle pulse after an accepted divisor < 2
//   busy         out  high in RUN or PEND
//   tick         out  1-cycle pulse on the last cycle of each period
//   low_clock    out  high for the first div/2 cycles of each period
//   tick_count   out  (DIV_TICK_COUNT_EN only) ticks since last RUN entry
module div_freq_ctrl #(
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             speed_clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic             tick,
  output logic             low_clock
`ifdef DIV_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two         = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cont_q, cont_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             cfg_err_q, cfg_err_d;

  logic             w_xfer;
  logic             w_cfg_legal;
  logic             w_last;
  logic             w_busy;

  assign w_busy      = (state_q != ST_IDLE);
  assign w_xfer      = cfg_valid & cfg_ready;
  assign w_cfg_legal = (cfg_div >= c_two);
  // cont only advances while busy, so w_last alone is meaningful in IDLE too
  // (cont is 0 there and div >= 2), but tick is still gated by busy.
  assign w_last      = (cont_q == (div_q - c_one));

  // Outputs decode registered state/cont directly: no extra latency.
  assign cfg_ready = (state_q != ST_PEND);
  assign cfg_err   = cfg_err_q;
  assign busy      = w_busy;
  assign tick      = w_busy & w_last;
  assign low_clock = w_busy & (cont_q < (div_q >> 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cont_d     = cont_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = w_xfer & ~w_cfg_legal;

    case (state_q)
      ST_IDLE: begin
        cont_d = '0;
        // A divisor accepted together with start governs the first period.
        if (w_xfer && w_cfg_legal) begin
          div_d = cfg_div;
        end
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          cont_d  = '0;
          // A divisor accepted on the stopping edge is committed directly.
          if (w_xfer && w_cfg_legal) begin
            div_d = cfg_div;
          end
        end else begin
          cont_d = w_last ? '0 : cont_q + c_one;
          if (w_xfer && w_cfg_legal) begin
            pend_div_d = cfg_div;
            state_d    = ST_PEND;
          end
        end
      end

      ST_PEND: begin
        if (stop) begin
          state_d = ST_IDLE;
          cont_d  = '0;
          div_d   = pend_div_q;
        end else if (w_last) begin
          // Changeover only at the period boundary keeps low_clock glitch-free.
          state_d = ST_RUN;
          cont_d  = '0;
          div_d   = pend_div_q;
        end else begin
          cont_d = cont_q + c_one;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cont_d  = '0;
      end
    endcase
  end

  always_ff @(posedge speed_clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      div_q      <= c_default_div;
      cont_q     <= '0;
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cont_q     <= cont_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef DIV_TICK_COUNT_EN
  logic [15:0] tick_count_q, tick_count_d;

  always_comb begin
    tick_count_d = tick_count_q;
    if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      tick_count_d = '0;
    end else if (tick) begin
      tick_count_d = tick_count_q + 16'd1;
    end
  end

  always_ff @(posedge speed_clock) begin
    if (!reset_n) begin
      tick_count_q <= '0;
    end else begin
      tick_count_q <= tick_count_d;
    end
  end

  assign tick_count = tick_count_q;
`endif

endmodule
`default_nettype wire
